// File: rtl/flex_counter.sv
// flex_counter: up-counter with programmable rollover value.
// Registered count and rollover flag; async active-high reset.
module flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  logic [NUM_BITS-1:0] next_count;
  logic                next_flag;

  // next count: clear beats enable; terminal value restarts at 1
  always_comb begin
    next_count = count_out;
    if (clear) begin
      next_count = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val)
        next_count = NUM_BITS'(1);
      else
        next_count = count_out + NUM_BITS'(1);
    end
  end

  // flag tracks the comparison of the count being loaded
  always_comb begin
    next_flag = 1'b0;
    if (!clear)
      next_flag = (next_count == rollover_val);
  end

  // count and flag registered together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
    end
  end

endmodule

// File: tb/tb_flex_counter.sv
// tb_flex_counter: directed scoreboard bench for flex_counter.
// Expectations queued when stimulus is driven, checked at negedge.
module tb_flex_counter;

  logic       tb_clk;
  logic       rst;
  logic       clear;
  logic       count_enable;
  logic [3:0] rollover_val;
  logic [3:0] count_out;
  logic       rollover_flag;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       flg;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  flex_counter #(.NUM_BITS(4)) dut (
    .clk          (tb_clk),
    .rst          (rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic push(string tag, logic [3:0] c, logic f);
    exp_t e;
    e.tag = tag;
    e.cnt = c;
    e.flg = f;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty: got no expectation, want one");
      return;
    end
    e = sb.pop_front();
    assert (count_out === e.cnt) passed++;
    else $error("FAIL %s count: got %0d want %0d",
                e.tag, count_out, e.cnt);
    total++;
    assert (rollover_flag === e.flg) passed++;
    else $error("FAIL %s flag: got %0b want %0b",
                e.tag, rollover_flag, e.flg);
  endtask

  task automatic edges(int n);
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic run(int n, string tag, logic [3:0] c, logic f);
    push(tag, c, f);
    edges(n);
    check();
  endtask

  task automatic reset_pulse();
    @(negedge tb_clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    clear        = 1'b0;
    count_enable = 1'b1;
    rollover_val = 4'd15;

    // reset: immediate, held through an edge, and at release
    push("rst_imm", 4'd0, 1'b0);
    #2;
    check();
    run(1, "rst_hold", 4'd0, 1'b0);
    rst = 1'b0;
    push("rst_rel", 4'd0, 1'b0);
    #1;
    check();

    // continuous count
    rollover_val = 4'd13;
    reset_pulse();
    run(10, "cont10", 4'd10, 1'b0);

    // rollover to 1
    rollover_val = 4'd11;
    reset_pulse();
    run(11, "roll_hit", 4'd11, 1'b1);
    run(1, "roll_to1", 4'd1, 1'b0);

    // clear / enable toggling
    rollover_val = 4'd9;
    reset_pulse();
    run(7, "ce_cnt7", 4'd7, 1'b0);
    clear = 1'b1;
    run(2, "ce_clr", 4'd0, 1'b0);
    clear = 1'b0;
    run(9, "ce_cnt9", 4'd9, 1'b1);
    count_enable = 1'b0;
    run(5, "ce_hold", 4'd9, 1'b1);

    // rollover_val changed while holding
    rollover_val = 4'd12;
    run(1, "hold_rv12", 4'd9, 1'b0);
    rollover_val = 4'd9;
    run(1, "hold_rv9", 4'd9, 1'b1);

    // rollover_val = 0: wrap to 0 raises flag, then 1
    count_enable = 1'b1;
    rollover_val = 4'd0;
    reset_pulse();
    run(15, "rv0_15", 4'd15, 1'b0);
    run(1, "rv0_wrap", 4'd0, 1'b1);
    run(1, "rv0_to1", 4'd1, 1'b0);

    // rollover_val = 1: sticks at 1 with flag
    rollover_val = 4'd1;
    run(1, "rv1_a", 4'd1, 1'b1);
    run(3, "rv1_b", 4'd1, 1'b1);

    // rollover_val lowered below count: no early rollover
    rollover_val = 4'd15;
    reset_pulse();
    run(6, "low_6", 4'd6, 1'b0);
    rollover_val = 4'd3;
    run(1, "low_7", 4'd7, 1'b0);
    run(9, "low_wrap", 4'd0, 1'b0);
    run(3, "low_hit", 4'd3, 1'b1);
    run(1, "low_to1", 4'd1, 1'b0);

    // clear and enable together
    clear = 1'b1;
    run(1, "clr_en", 4'd0, 1'b0);
    clear = 1'b0;

    // async reset mid-count
    rollover_val = 4'd15;
    reset_pulse();
    run(5, "async_5", 4'd5, 1'b0);
    #2;
    rst = 1'b1;
    push("async_imm", 4'd0, 1'b0);
    #1;
    check();
    run(1, "async_hold", 4'd0, 1'b0);
    rst = 1'b0;
    run(1, "async_res", 4'd1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
